// File: rtl/id_stage_hs_pkg.sv
// Shared decode types for id_stage_hs: opcodes, control word, FSM state,
// and the control-ROM / immediate-generator helpers.
package id_stage_hs_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {IMM_ZERO, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_t;
  typedef enum logic {ID_RUN, ID_LDUSE} id_state_t;

  typedef struct packed {
    logic [6:0] opcode;
    logic [3:0] alu_op;
    imm_sel_t   imm_sel;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_src;
  } rv32i_control_word;

  function automatic logic uses_rs1(input logic [6:0] op);
    return (op == OP_REG) || (op == OP_IMM) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_JALR);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_REG) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

  function automatic logic uses_rd(input logic [6:0] op);
    return (op == OP_REG) || (op == OP_IMM) || (op == OP_LOAD) || (op == OP_LUI) ||
           (op == OP_AUIPC) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

  function automatic rv32i_control_word control_rom(input logic [31:0] instr);
    rv32i_control_word c;
    c = '0;
    c.opcode = instr[6:0];
    case (instr[6:0])
      OP_REG:    c.alu_op = {instr[30], instr[14:12]};
      OP_IMM: begin
        c.alu_op  = {instr[30] & (instr[14:12] == 3'b101), instr[14:12]};
        c.imm_sel = IMM_I;
        c.alu_src = 1'b1;
      end
      OP_LOAD: begin
        c.mem_read = 1'b1;
        c.imm_sel  = IMM_I;
        c.alu_src  = 1'b1;
      end
      OP_STORE: begin
        c.mem_write = 1'b1;
        c.imm_sel   = IMM_S;
        c.alu_src   = 1'b1;
      end
      OP_BRANCH: begin
        c.branch  = 1'b1;
        c.alu_op  = {1'b0, instr[14:12]};
        c.imm_sel = IMM_B;
      end
      OP_JAL: begin
        c.jump    = 1'b1;
        c.imm_sel = IMM_J;
      end
      OP_JALR: begin
        c.jump    = 1'b1;
        c.imm_sel = IMM_I;
        c.alu_src = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        c.imm_sel = IMM_U;
        c.alu_src = 1'b1;
      end
      default: c = '0;
    endcase
    c.reg_write = uses_rd(instr[6:0]);
    return c;
  endfunction

  function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_sel_t sel);
    logic [31:0] imm;
    case (sel)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'd0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/id_stage_hs_id_ex_reg.sv
// ID/EX payload register with valid/ready advance, bubble insertion and flush.
module id_ex_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         adv_i,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // A flush kills the slot; on advance, load a new op or a bubble; otherwise hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (adv_i) begin
      valid_d = load_i;
      data_d  = load_i ? data_i : data_q;
    end else begin
      valid_d = valid_q;
    end
  end

  // Slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/id_stage_hs.sv
// Decode stage: decoder, control ROM, regfile, load-use interlock and owned ID/EX register.
// Define ID_WB_BYPASS_EN to make same-cycle writeback visible to the regfile read ports.
module id_stage_hs
  import id_stage_hs_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [31:0]       if_instr,
  input  logic [XLEN-1:0]   if_pc_plus4,
  input  logic              if_is_branch,
  input  logic              branch_recovery,
  input  logic              wb_load,
  input  logic [4:0]        wb_dest,
  input  logic [XLEN-1:0]   wb_data,
  output logic              ex_valid,
  input  logic              ex_ready,
  output rv32i_control_word ex_ctrl,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_pc_plus4,
  output logic              ex_is_branch,
  output logic              ex_illegal
);

  localparam int REG_AW = $clog2(NUM_REGS);
  localparam int PW     = $bits(rv32i_control_word) + 4 * XLEN + 17;

  function automatic logic reg_ok(input logic [4:0] idx);
    return ({27'd0, idx} < NUM_REGS);
  endfunction

  logic [XLEN-1:0]   regs_q [NUM_REGS];
  id_state_t         state_q, state_d;
  rv32i_control_word ctrl_rom, ctrl;
  logic [4:0]        rs1, rs2, rd;
  logic              illegal, hazard, adv, capture, byp1, byp2;
  logic [XLEN-1:0]   imm, rs1_data, rs2_data;
  logic [PW-1:0]     payload_d, payload_q;

  // Field extraction; unused source/dest fields read as x0 so they never match a hazard.
  always_comb begin
    rs1      = uses_rs1(if_instr[6:0]) ? if_instr[19:15] : 5'd0;
    rs2      = uses_rs2(if_instr[6:0]) ? if_instr[24:20] : 5'd0;
    rd       = uses_rd(if_instr[6:0])  ? if_instr[11:7]  : 5'd0;
    illegal  = !reg_ok(rs1) || !reg_ok(rs2) || !reg_ok(rd);
    ctrl_rom = control_rom(if_instr);
    ctrl     = illegal ? '0 : ctrl_rom;
    imm      = XLEN'($signed(imm_gen(if_instr, ctrl_rom.imm_sel)));
  end

`ifdef ID_WB_BYPASS_EN
  assign byp1 = wb_load && (wb_dest == rs1);
  assign byp2 = wb_load && (wb_dest == rs2);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  // Regfile read ports: x0 and out-of-range indices read as zero.
  always_comb begin
    rs1_data = (rs1 == 5'd0 || !reg_ok(rs1)) ? '0 :
               (byp1 ? wb_data : regs_q[rs1[REG_AW-1:0]]);
    rs2_data = (rs2 == 5'd0 || !reg_ok(rs2)) ? '0 :
               (byp2 ? wb_data : regs_q[rs2[REG_AW-1:0]]);
  end

  // Regfile write port; storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wb_load && wb_dest != 5'd0 && reg_ok(wb_dest)) begin
      regs_q[wb_dest[REG_AW-1:0]] <= wb_data;
    end
  end

  assign adv    = !ex_valid || ex_ready;
  assign hazard = if_valid && ex_valid && (ex_ctrl.opcode == OP_LOAD) && (ex_rd != 5'd0) &&
                  ((ex_rd == rs1) || (ex_rd == rs2));

  // Interlock state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ID_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: recovery always returns to RUN; LDUSE lasts a single advancing cycle.
  always_comb begin
    state_d = state_q;
    if (branch_recovery) begin
      state_d = ID_RUN;
    end else begin
      case (state_q)
        ID_RUN:   state_d = (hazard && adv) ? ID_LDUSE : ID_RUN;
        ID_LDUSE: state_d = adv ? ID_RUN : ID_LDUSE;
        default:  state_d = ID_RUN;
      endcase
    end
  end

  // Handshake outputs.
  always_comb begin
    if_ready = adv && (state_q == ID_RUN) && !hazard && !branch_recovery;
    capture  = if_valid && if_ready;
  end

  assign payload_d = {ctrl, imm, rs1, rs2, rd, rs1_data, rs2_data, if_pc_plus4, if_is_branch, illegal};

  id_ex_reg #(.W(PW)) u_id_ex_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (branch_recovery),
    .adv_i   (adv),
    .load_i  (capture),
    .data_i  (payload_d),
    .valid_o (ex_valid),
    .data_o  (payload_q)
  );

  assign {ex_ctrl, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data,
          ex_pc_plus4, ex_is_branch, ex_illegal} = payload_q;

endmodule

// File: tb/tb_id_stage_hs.sv
// Directed bench for id_stage_hs: a default instance and an RV32E (NUM_REGS=16) instance.
module tb_id_stage_hs;
  import id_stage_hs_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, if_valid, if_is_branch, branch_recovery, wb_load, ex_ready;
  logic [31:0] if_instr, if_pc_plus4, wb_data;
  logic [4:0]  wb_dest;

  logic a_if_ready, a_ex_valid, a_ex_is_branch, a_ex_illegal;
  rv32i_control_word a_ex_ctrl;
  logic [31:0] a_ex_imm, a_ex_rs1_data, a_ex_rs2_data, a_ex_pc_plus4;
  logic [4:0]  a_ex_rs1, a_ex_rs2, a_ex_rd;

  logic b_if_ready, b_ex_valid, b_ex_is_branch, b_ex_illegal;
  rv32i_control_word b_ex_ctrl;
  logic [31:0] b_ex_imm, b_ex_rs1_data, b_ex_rs2_data, b_ex_pc_plus4;
  logic [4:0]  b_ex_rs1, b_ex_rs2, b_ex_rd;

  int checks = 0;
  int failures = 0;
  rv32i_control_word exp_c;

  always #5 clk = ~clk;

  id_stage_hs dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(a_if_ready), .if_instr(if_instr),
    .if_pc_plus4(if_pc_plus4), .if_is_branch(if_is_branch), .branch_recovery(branch_recovery),
    .wb_load(wb_load), .wb_dest(wb_dest), .wb_data(wb_data), .ex_valid(a_ex_valid),
    .ex_ready(ex_ready), .ex_ctrl(a_ex_ctrl), .ex_imm(a_ex_imm), .ex_rs1(a_ex_rs1),
    .ex_rs2(a_ex_rs2), .ex_rd(a_ex_rd), .ex_rs1_data(a_ex_rs1_data), .ex_rs2_data(a_ex_rs2_data),
    .ex_pc_plus4(a_ex_pc_plus4), .ex_is_branch(a_ex_is_branch), .ex_illegal(a_ex_illegal)
  );

  id_stage_hs #(.NUM_REGS(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(b_if_ready), .if_instr(if_instr),
    .if_pc_plus4(if_pc_plus4), .if_is_branch(if_is_branch), .branch_recovery(branch_recovery),
    .wb_load(wb_load), .wb_dest(wb_dest), .wb_data(wb_data), .ex_valid(b_ex_valid),
    .ex_ready(ex_ready), .ex_ctrl(b_ex_ctrl), .ex_imm(b_ex_imm), .ex_rs1(b_ex_rs1),
    .ex_rs2(b_ex_rs2), .ex_rd(b_ex_rd), .ex_rs1_data(b_ex_rs1_data), .ex_rs2_data(b_ex_rs2_data),
    .ex_pc_plus4(b_ex_pc_plus4), .ex_is_branch(b_ex_is_branch), .ex_illegal(b_ex_illegal)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [4:0] d, input logic [31:0] v);
    wb_load = 1'b1; wb_dest = d; wb_data = v;
    tick();
    wb_load = 1'b0;
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs2, input logic [4:0] rs1, input logic [4:0] rd);
    return {7'd0, rs2, rs1, 3'b000, rd, OP_REG};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  initial begin
    rst_n = 1'b0; if_valid = 1'b0; if_instr = 32'd0; if_pc_plus4 = 32'h0000_1004;
    if_is_branch = 1'b0; branch_recovery = 1'b0; wb_load = 1'b0; wb_dest = 5'd0;
    wb_data = 32'd0; ex_ready = 1'b1;
    #2;
    check_eq("rst_valid", a_ex_valid, 64'd0);
    check_eq("rst_ctrl", a_ex_ctrl, 64'd0);
    check_eq("rst_imm", a_ex_imm, 64'd0);
    check_eq("rst_if_ready", a_if_ready, 64'd1);
    tick(); tick();
    rst_n = 1'b1;
    wr_reg(5'd1, 32'h100); wr_reg(5'd2, 32'h22); wr_reg(5'd4, 32'h44);
    wr_reg(5'd5, 32'h55);  wr_reg(5'd7, 32'h77); wr_reg(5'd0, 32'h123);

    // addi x3, x1, -5
    if_valid = 1'b1; if_is_branch = 1'b1;
    if_instr = enc_i(12'hFFB, 5'd1, 3'b000, 5'd3, OP_IMM);
    #1 check_eq("addi_ready", a_if_ready, 64'd1);
    tick();
    exp_c = '0; exp_c.opcode = OP_IMM; exp_c.imm_sel = IMM_I; exp_c.reg_write = 1'b1; exp_c.alu_src = 1'b1;
    check_eq("addi_valid", a_ex_valid, 64'd1);
    check_eq("addi_ctrl", a_ex_ctrl, exp_c);
    check_eq("addi_rd", a_ex_rd, 64'd3);
    check_eq("addi_rs1", a_ex_rs1, 64'd1);
    check_eq("addi_rs2", a_ex_rs2, 64'd0);
    check_eq("addi_rs1_data", a_ex_rs1_data, 64'h100);
    check_eq("addi_imm", a_ex_imm, 64'hFFFF_FFFB);
    check_eq("addi_pc", a_ex_pc_plus4, 64'h1004);
    check_eq("addi_br", a_ex_is_branch, 64'd1);
    if_valid = 1'b0; if_is_branch = 1'b0;
    tick();
    check_eq("idle_valid", a_ex_valid, 64'd0);

    // Load-use: lw x5,0(x1) then add x6,x5,x2
    if_valid = 1'b1;
    if_instr = enc_i(12'd0, 5'd1, 3'b010, 5'd5, OP_LOAD);
    tick();
    exp_c = '0; exp_c.opcode = OP_LOAD; exp_c.imm_sel = IMM_I; exp_c.reg_write = 1'b1;
    exp_c.mem_read = 1'b1; exp_c.alu_src = 1'b1;
    check_eq("lw_valid", a_ex_valid, 64'd1);
    check_eq("lw_ctrl", a_ex_ctrl, exp_c);
    if_instr = enc_r(5'd2, 5'd5, 5'd6);
    #1 check_eq("hz_ready", a_if_ready, 64'd0);
    tick();
    check_eq("hz_bubble", a_ex_valid, 64'd0);
    check_eq("ldu_ready", a_if_ready, 64'd0);
    tick();
    check_eq("ldu_valid", a_ex_valid, 64'd0);
    check_eq("run_ready", a_if_ready, 64'd1);
    tick();
    check_eq("add_valid", a_ex_valid, 64'd1);
    check_eq("add_rd", a_ex_rd, 64'd6);
    check_eq("add_rs2", a_ex_rs2, 64'd2);
    check_eq("add_rs1_data", a_ex_rs1_data, 64'h55);
    check_eq("add_rs2_data", a_ex_rs2_data, 64'h22);

    // Backpressure with ori x9,x4,1 waiting
    ex_ready = 1'b0;
    if_instr = enc_i(12'd1, 5'd4, 3'b110, 5'd9, OP_IMM);
    for (int i = 0; i < 3; i++) begin
      #1 check_eq("bp_ready", a_if_ready, 64'd0);
      tick();
      check_eq("bp_valid", a_ex_valid, 64'd1);
      check_eq("bp_rd", a_ex_rd, 64'd6);
      check_eq("bp_rs1_data", a_ex_rs1_data, 64'h55);
    end
    ex_ready = 1'b1;
    #1 check_eq("drain_ready", a_if_ready, 64'd1);
    tick();
    check_eq("drain_rd", a_ex_rd, 64'd9);
    check_eq("drain_rs1_data", a_ex_rs1_data, 64'h44);
    check_eq("drain_imm", a_ex_imm, 64'd1);

    // Flush while in LDUSE
    if_instr = enc_i(12'd0, 5'd1, 3'b010, 5'd5, OP_LOAD);
    tick();
    if_instr = enc_r(5'd2, 5'd5, 5'd6);
    tick();
    check_eq("fl_ldu_valid", a_ex_valid, 64'd0);
    branch_recovery = 1'b1;
    #1 check_eq("fl_ready", a_if_ready, 64'd0);
    tick();
    branch_recovery = 1'b0;
    check_eq("fl_valid", a_ex_valid, 64'd0);
    #1 check_eq("fl_run_ready", a_if_ready, 64'd1);
    tick();
    check_eq("fl_add_valid", a_ex_valid, 64'd1);

    // Flush a valid, stalled op
    ex_ready = 1'b0; branch_recovery = 1'b1;
    if_instr = enc_i(12'd1, 5'd4, 3'b110, 5'd9, OP_IMM);
    #1 check_eq("flv_ready", a_if_ready, 64'd0);
    tick();
    check_eq("flv_valid", a_ex_valid, 64'd0);
    branch_recovery = 1'b0; ex_ready = 1'b1;
    tick();
    check_eq("flv_next_rd", a_ex_rd, 64'd9);

    // Same-cycle writeback of x7 while reading x7
    if_instr = enc_i(12'd0, 5'd7, 3'b000, 5'd10, OP_IMM);
    wb_load = 1'b1; wb_dest = 5'd7; wb_data = 32'hDEAD_BEEF;
    tick();
    wb_load = 1'b0;
`ifdef ID_WB_BYPASS_EN
    check_eq("byp_same", a_ex_rs1_data, 64'hDEAD_BEEF);
`else
    check_eq("byp_same", a_ex_rs1_data, 64'h77);
`endif
    tick();
    check_eq("byp_after", a_ex_rs1_data, 64'hDEAD_BEEF);

    // x0 write dropped
    if_instr = enc_i(12'd0, 5'd0, 3'b000, 5'd13, OP_IMM);
    tick();
    check_eq("x0_read", a_ex_rs1_data, 64'd0);

    // RV32E illegal register
    if_instr = enc_r(5'd2, 5'd1, 5'd20);
    tick();
    check_eq("ill16_flag", b_ex_illegal, 64'd1);
    check_eq("ill16_ctrl", b_ex_ctrl, 64'd0);
    check_eq("ill16_valid", b_ex_valid, 64'd1);
    check_eq("ill32_flag", a_ex_illegal, 64'd0);
    wb_load = 1'b1; wb_dest = 5'd20; wb_data = 32'h0000_0BAD;
    if_instr = enc_i(12'd0, 5'd4, 3'b000, 5'd11, OP_IMM);
    tick();
    wb_load = 1'b0;
    tick();
    check_eq("ill16_x4", b_ex_rs1_data, 64'h44);
    check_eq("ill32_x4", a_ex_rs1_data, 64'h44);
    if_instr = enc_i(12'd0, 5'd20, 3'b000, 5'd12, OP_IMM);
    tick();
    check_eq("x20_32", a_ex_rs1_data, 64'hBAD);
    check_eq("x20_16_ill", b_ex_illegal, 64'd1);

    // Reset mid-stream
    check_eq("mid_pre_valid", a_ex_valid, 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_valid", a_ex_valid, 64'd0);
    check_eq("mid_rd", a_ex_rd, 64'd0);
    check_eq("mid_rs1_data", a_ex_rs1_data, 64'd0);
    tick();
    check_eq("mid_pc", a_ex_pc_plus4, 64'd0);
    check_eq("mid_imm", a_ex_imm, 64'd0);
    check_eq("mid_ctrl", a_ex_ctrl, 64'd0);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
